// File: rtl/rice_reader_pkg.sv
// Shared types and helpers for the Rice bitstream reader.
// Fold/unfold map signed residuals to unsigned codes and back.
package rice_reader_pkg;

  localparam int RICE_PARAM_W = 4;
  localparam int WORD_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_ALIGN,
    S_UNARY,
    S_BIN,
    S_OUT
  } state_t;

  function automatic logic [WORD_W-1:0] rice_fold(
    input logic [WORD_W-1:0] r
  );
    return {r[WORD_W-2:0], 1'b0} ^ {WORD_W{r[WORD_W-1]}};
  endfunction

  function automatic logic [WORD_W-1:0] rice_unfold(
    input logic [WORD_W-1:0] u
  );
    return (u >> 1) ^ {WORD_W{u[0]}};
  endfunction

endpackage

// File: rtl/rice_clz32.sv
// Leading-zero count over the valid (top 'fill') bits of a
// left-justified 32-bit word; all_zero when no '1' is valid.
module rice_clz32
  import rice_reader_pkg::*;
(
  input  logic [31:0] word,
  input  logic [5:0]  fill,
  output logic [5:0]  count,
  output logic        all_zero
);

  logic found;

  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!found && (6'(i) < fill) && word[31-i]) begin
        count = 6'(i);
        found = 1'b1;
      end
    end
    all_zero = !found;
  end

endmodule

// File: rtl/rice_reader.sv
// Rice code reader: fetches MSB-first 16-bit words from RAM and
// decodes q zeros, stop '1', k remainder bits per code.
module rice_reader
  import rice_reader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int QUOT_W = 16
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iEnable,
  input  logic                    iStart,
  input  logic [ADDR_W-1:0]       iStartAddress,
  input  logic                    iLoadParam,
  input  logic                    iAlign,
  output logic                    oRamReadEnable,
  output logic [ADDR_W-1:0]       oRamAddress,
  input  logic [WORD_W-1:0]       iRamData,
  output logic [RICE_PARAM_W-1:0] oParam,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [QUOT_W-1:0]       oQuotient,
  output logic [WORD_W-1:0]       oRemainder,
  output logic [WORD_W-1:0]       oFolded,
  output logic [WORD_W-1:0]       oResidual,
  output logic                    oBusy,
  output logic                    oError
);

  localparam int QS_W = QUOT_W + 7;

  state_t                  state;
  state_t                  state_nx;
  logic [31:0]             bits;
  logic [31:0]             bits_sh;
  logic [31:0]             bits_nx;
  logic [5:0]              fill;
  logic [5:0]              fill_sh;
  logic [5:0]              fill_nx;
  logic                    pending;
  logic                    rd;
  logic [ADDR_W-1:0]       addr;
  logic [QUOT_W-1:0]       q;
  logic [QUOT_W-1:0]       q_sat;
  logic [QS_W-1:0]         q_sum;
  logic                    q_ovf;
  logic [RICE_PARAM_W-1:0] k;
  logic [5:0]              n;
  logic [5:0]              q_add;
  logic [5:0]              lz;
  logic                    all_zero;
  logic                    q_step;
  logic                    q_clr;
  logic                    k_load;
  logic                    emit;
  logic [WORD_W-1:0]       rem;
  logic [WORD_W-1:0]       folded;

  rice_clz32 u_clz (
    .word     (bits),
    .fill     (fill),
    .count    (lz),
    .all_zero (all_zero)
  );

  assign rd = iEnable && !iStart && !iReset &&
              ((7'(fill) + (pending ? 7'd16 : 7'd0)) <= 7'd16);

  assign oRamReadEnable = rd;
  assign oRamAddress    = addr;
  assign oParam         = k;
  assign oBusy          = (state != S_IDLE);

  assign rem    = bits[31:16] >> (5'd16 - {1'b0, k});
  assign folded = (WORD_W'(q) << k) | rem;

  assign q_sum = QS_W'(q) + QS_W'(q_add);
  assign q_ovf = |q_sum[QS_W-1:QUOT_W];
  assign q_sat = q_ovf ? '1 : q_sum[QUOT_W-1:0];

  always_comb begin
    state_nx = state;
    n        = '0;
    q_add    = '0;
    q_step   = 1'b0;
    q_clr    = 1'b0;
    k_load   = 1'b0;
    emit     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (iLoadParam)     state_nx = S_PARAM;
        else if (iAlign)    state_nx = S_ALIGN;
        else if (fill != 0) state_nx = S_UNARY;
      end
      S_PARAM: begin
        if (fill >= 6'd4) begin
          k_load   = 1'b1;
          n        = 6'd4;
          state_nx = S_IDLE;
        end
      end
      S_ALIGN: begin
        n        = {2'b00, fill[3:0]};
        state_nx = S_IDLE;
      end
      S_UNARY: begin
        q_step = 1'b1;
        if (all_zero) begin
          q_add = fill;
          n     = fill;
        end else begin
          q_add    = lz;
          n        = lz + 6'd1;
          state_nx = S_BIN;
        end
      end
      S_BIN: begin
        if (fill >= {2'b00, k}) begin
          n        = {2'b00, k};
          emit     = 1'b1;
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        if (iReady) begin
          q_clr    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // consume first, then append the returning word below what is left
  always_comb begin
    bits_sh = bits;
    fill_sh = fill;
    if (iEnable) begin
      bits_sh = bits << n;
      fill_sh = fill - n;
    end
    bits_nx = bits_sh;
    fill_nx = fill_sh;
    if (pending) begin
      bits_nx = bits_sh | ({iRamData, 16'h0000} >> fill_sh);
      fill_nx = fill_sh + 6'd16;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)       state <= S_IDLE;
    else if (iStart)  state <= S_IDLE;
    else if (iEnable) state <= state_nx;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      bits       <= '0;
      fill       <= '0;
      pending    <= 1'b0;
      addr       <= '0;
      q          <= '0;
      k          <= '0;
      oValid     <= 1'b0;
      oError     <= 1'b0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oFolded    <= '0;
      oResidual  <= '0;
    end else if (iStart) begin
      bits    <= '0;
      fill    <= '0;
      pending <= 1'b0;
      addr    <= iStartAddress;
      q       <= '0;
      oValid  <= 1'b0;
      oError  <= 1'b0;
    end else begin
      bits    <= bits_nx;
      fill    <= fill_nx;
      pending <= rd;
      if (rd) addr <= addr + ADDR_W'(1);
      if (iEnable) begin
        if (k_load) k <= bits[31:28];
        if (q_clr) begin
          q      <= '0;
          oValid <= 1'b0;
        end else if (q_step) begin
          q <= q_sat;
          if (q_ovf) oError <= 1'b1;
        end
        if (emit) begin
          oValid     <= 1'b1;
          oQuotient  <= q;
          oRemainder <= rem;
          oFolded    <= folded;
          oResidual  <= rice_unfold(folded);
        end
      end
    end
  end

endmodule
